// File: rtl/conv2_out_ser_if.sv
// Beat-in / pixel-out handshake bundle for the conv2 output serializer.
// Slave side is the serializer; master side is the surrounding fabric.
interface conv2_out_ser_if #(
  parameter int DATA_BIT = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_BIT-1:0] in_data_0;
  logic [DATA_BIT-1:0] in_data_1;
  logic [DATA_BIT-1:0] in_data_2;
  logic [DATA_BIT-1:0] in_data_3;
  logic [DATA_BIT-1:0] in_data_4;
  logic [DATA_BIT-1:0] in_data_5;
  logic [DATA_BIT-1:0] in_data_6;
  logic [DATA_BIT-1:0] in_data_7;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_BIT-1:0] out_data;
  logic                out_eol;
  logic                out_eof;
  logic                frame_done;

  modport slave (
    input  in_valid, out_ready,
    input  in_data_0, in_data_1, in_data_2, in_data_3,
    input  in_data_4, in_data_5, in_data_6, in_data_7,
    output in_ready, out_valid, out_data,
    output out_eol, out_eof, frame_done
  );

  modport master (
    output in_valid, out_ready,
    output in_data_0, in_data_1, in_data_2, in_data_3,
    output in_data_4, in_data_5, in_data_6, in_data_7,
    input  in_ready, out_valid, out_data,
    input  out_eol, out_eof, frame_done
  );
endinterface

// File: rtl/conv2_out_ser.sv
// Ping-pong 8-lane to 1-pixel serializer for the conv2 output map,
// tagging end-of-row / end-of-frame and pulsing frame_done.
module conv2_out_ser #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int DATA_BIT = 12,
  parameter int LANES    = 8
) (
  input logic            clk,
  input logic            rst,
  conv2_out_ser_if.slave io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [DATA_BIT-1:0] bank_q [2][LANES];
  logic [DATA_BIT-1:0] bank_d [2][LANES];
  logic [DATA_BIT-1:0] lane_in [LANES];
  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [2:0]    lane_q, lane_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;

  logic in_rdy, out_vld, in_fire, out_fire;
  logic last_lane, col_last, row_last, eol, eof;

  assign lane_in[0] = io.in_data_0;
  assign lane_in[1] = io.in_data_1;
  assign lane_in[2] = io.in_data_2;
  assign lane_in[3] = io.in_data_3;
  assign lane_in[4] = io.in_data_4;
  assign lane_in[5] = io.in_data_5;
  assign lane_in[6] = io.in_data_6;
  assign lane_in[7] = io.in_data_7;

  assign in_rdy    = ~full_q[wr_sel_q];
  assign out_vld   = full_q[rd_sel_q];
  assign in_fire   = io.in_valid & in_rdy;
  assign out_fire  = out_vld & io.out_ready;
  assign last_lane = out_fire & (lane_q == 3'(LANES - 1));
  assign col_last  = col_q == CW'(WIDTH - 1);
  assign row_last  = row_q == RW'(HEIGHT - 1);
  assign eol       = out_vld & col_last;
  assign eof       = eol & row_last;

  // Write and read always hit different banks, so both may act at once.
  always_comb begin
    bank_d   = bank_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    lane_d   = lane_q;
    col_d    = col_q;
    row_d    = row_q;
    done_d   = out_fire & eof;
    if (in_fire) begin
      bank_d[wr_sel_q] = lane_in;
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (out_fire) begin
      lane_d = lane_q + 3'd1;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (last_lane) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      lane_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      lane_q   <= lane_d;
      col_q    <= col_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  // Gating by valid keeps stale bank contents off the bus during reset.
  assign io.in_ready   = in_rdy;
  assign io.out_valid  = out_vld;
  assign io.out_data   = out_vld ? bank_q[rd_sel_q][lane_q] : '0;
  assign io.out_eol    = eol;
  assign io.out_eof    = eof;
  assign io.frame_done = done_q;
endmodule

// File: tb/tb_conv2_out_ser.sv
// Directed vector table plus scoreboarded sequences for conv2_out_ser.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_conv2_out_ser;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DB = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv2_out_ser_if #(.DATA_BIT(DB)) bus();

  conv2_out_ser #(
    .WIDTH(W), .HEIGHT(H), .DATA_BIT(DB), .LANES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  typedef struct {
    logic          iv;
    logic [DB-1:0] base;
    logic          ordy;
    logic          ir;
    logic          ov;
    logic [DB-1:0] od;
    logic          eol;
    logic          eof;
  } vec_t;

  vec_t          vq[$];
  logic [DB-1:0] din[8];
  logic [DB-1:0] expq[$];
  int checks = 0;
  int errors = 0;
  int opix = 0;
  int frames = 0;
  int fd_cnt = 0;
  bit exp_done = 0;
  bit mon_on = 0;
  bit last_ov = 0;
  bit last_in = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_in();
    bus.in_data_0 = din[0];
    bus.in_data_1 = din[1];
    bus.in_data_2 = din[2];
    bus.in_data_3 = din[3];
    bus.in_data_4 = din[4];
    bus.in_data_5 = din[5];
    bus.in_data_6 = din[6];
    bus.in_data_7 = din[7];
  endtask

  task automatic set_base(input logic [DB-1:0] b);
    for (int k = 0; k < 8; k++) din[k] = b + DB'(k);
    drive_in();
  endtask

  function automatic vec_t mk(logic iv, logic [DB-1:0] base, logic ordy,
                              logic ir, logic ov, logic [DB-1:0] od,
                              logic eol, logic eof);
    vec_t v;
    v.iv = iv; v.base = base; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.eol = eol; v.eof = eof;
    return v;
  endfunction

  task automatic step();
    logic [DB-1:0] e;
    @(negedge clk);
    last_in = bus.in_valid && bus.in_ready;
    last_ov = bus.out_valid;
    if (mon_on) begin
      if (last_in) for (int k = 0; k < 8; k++) expq.push_back(din[k]);
      chk("frame_done", bus.frame_done, exp_done);
      if (bus.frame_done) fd_cnt++;
      exp_done = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel got %0h want none", bus.out_data);
        end else begin
          e = expq.pop_front();
          chk("pixel", bus.out_data, e);
        end
        chk("eol", bus.out_eol, (opix % W) == W - 1);
        chk("eof", bus.out_eof, opix == W * H - 1);
        if (opix == W * H - 1) begin
          opix = 0;
          frames++;
          exp_done = 1;
        end else begin
          opix++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    expq.delete();
    opix = 0;
    frames = 0;
    fd_cnt = 0;
    exp_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, cyc, gaps, outs, nb;
    bit started;
    vec_t v;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_base('0);

    // single beat 1..8
    vq.push_back(mk(1, 12'd1, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 0, 1, 1, 1, DB'(i + 1), i == 7, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    // backpressure: three beats, stall, drain
    vq.push_back(mk(1, 12'h100, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 12'h200, 0, 1, 1, 12'h100, 0, 0));
    vq.push_back(mk(1, 12'h300, 0, 0, 1, 12'h100, 0, 0));
    vq.push_back(mk(1, 12'h300, 0, 0, 1, 12'h100, 0, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(1, 12'h300, 1, 0, 1, 12'h100 + DB'(i), i == 7, 0));
    vq.push_back(mk(1, 12'h300, 0, 1, 1, 12'h200, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 12'h200, 0, 0));

    #3;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_eol", bus.out_eol, 0);
    chk("rst_eof", bus.out_eof, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      v = vq[i];
      bus.in_valid  = v.iv;
      bus.out_ready = v.ordy;
      set_base(v.base);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, v.ir);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, v.ov);
      chk($sformatf("vec%0d_out_data", i), bus.out_data, v.od);
      chk($sformatf("vec%0d_eol", i), bus.out_eol, v.eol);
      chk($sformatf("vec%0d_eof", i), bus.out_eof, v.eof);
      @(posedge clk);
      #1;
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back full frame
    mon_clear();
    mon_on = 1;
    bus.out_ready = 1'b1;
    b = 0;
    set_base('0);
    bus.in_valid = 1'b1;
    gaps = 0; outs = 0; cyc = 0; started = 0;
    while (frames < 1 && cyc < 300) begin
      step();
      cyc++;
      if (last_in) begin
        b++;
        if (b == 8) bus.in_valid = 1'b0;
        else set_base(DB'(b * 8));
      end
      if (last_ov) begin
        started = 1;
        outs++;
      end else if (started && outs < 64) begin
        gaps++;
      end
    end
    if (cyc >= 300) begin
      checks++;
      errors++;
      $display("FAIL b2b_timeout got %0d want <300", cyc);
    end
    chk("b2b_gaps", gaps, 0);
    chk("b2b_pixels", outs, 64);
    step();
    step();
    chk("b2b_frames", frames, 1);
    chk("b2b_done_pulses", fd_cnt, 1);
    chk("b2b_drained", expq.size(), 0);

    // input accepted on the same edge as the final-lane output
    set_base(12'h400);
    bus.in_valid = 1'b1;
    step();
    chk("sim_first_acc", last_in, 1);
    bus.in_valid = 1'b0;
    set_base(12'h500);
    for (int i = 0; i < 7; i++) step();
    bus.in_valid = 1'b1;
    chk("sim_in_ready", bus.in_ready, 1);
    chk("sim_lane7", bus.out_data, 12'h407);
    step();
    chk("sim_second_acc", last_in, 1);
    bus.in_valid = 1'b0;
    chk("sim_no_gap", bus.out_valid, 1);
    chk("sim_next_data", bus.out_data, 12'h500);
    for (int i = 0; i < 9; i++) step();
    chk("sim_drained", expq.size(), 0);
    chk("sim_idle", bus.out_valid, 0);

    // asynchronous reset after three beats of a frame
    b = 0;
    set_base(12'h600);
    bus.in_valid = 1'b1;
    cyc = 0;
    while (b < 3 && cyc < 100) begin
      step();
      cyc++;
      if (last_in) begin
        b++;
        set_base(12'h600 + DB'(b * 8));
      end
    end
    bus.in_valid = 1'b0;
    chk("mid_beats", b, 3);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_out_data", bus.out_data, 0);
    chk("mid_eol", bus.out_eol, 0);
    chk("mid_eof", bus.out_eof, 0);
    chk("mid_frame_done", bus.frame_done, 0);
    chk("mid_in_ready", bus.in_ready, 1);
    mon_clear();
    #1;
    rst = 1'b1;

    // random in_valid / out_ready over three frames
    nb = 0;
    cyc = 0;
    while (frames < 3 && cyc < 5000) begin
      if (nb < 24 && !bus.in_valid && ($urandom % 2 == 1)) begin
        for (int k = 0; k < 8; k++) din[k] = DB'($urandom);
        drive_in();
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom % 2 == 1);
      step();
      cyc++;
      if (last_in) begin
        nb++;
        bus.in_valid = 1'b0;
      end
    end
    if (cyc >= 5000) begin
      checks++;
      errors++;
      $display("FAIL rand_timeout got %0d want <5000", cyc);
    end
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rand_frames", frames, 3);
    chk("rand_done_pulses", fd_cnt, 3);
    chk("rand_beats", nb, 24);
    chk("rand_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv2_out_ser.md
CONV2_OUT_SER -- requirements
Module: conv2_out_ser

Interface
REQ-001 SHALL have parameters, one per line:
  WIDTH, 8, output feature-map width in pixels; SHALL be a multiple of LANES.
  HEIGHT, 8, output feature-map height in rows.
  DATA_BIT, 12, bits per pixel.
  LANES, 8, pixels per input beat; fixed at 8.
REQ-002 SHALL have ports, one per line:
  clk  input  1  single clock; all state changes on its rising edge.
  rst  input  1  asynchronous, active-low reset.
  in_valid  input  1  the in_data_0..7 lanes hold one beat.
  in_ready  output  1  the block accepts a beat this cycle.
  in_data_0 .. in_data_7  input  DATA_BIT each  the beat; lane 0 is the leftmost pixel.
  out_valid  output  1  out_data holds a pixel.
  out_ready  input  1  downstream accepts the pixel this cycle.
  out_data  output  DATA_BIT  the serialized pixel.
  out_eol  output  1  out_data is the last pixel of a row.
  out_eof  output  1  out_data is the last pixel of the frame.
  frame_done  output  1  one-cycle pulse after the last pixel of the frame transfers.
REQ-003 The clock SHALL be clk; the reset SHALL be rst, asynchronous and active-low.

Function
REQ-004 Storage SHALL be two banks (ping-pong, bank 0 and bank 1) of LANES x DATA_BIT registers, each with a full flag.
REQ-005 An input transfer SHALL occur only when in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL equal NOT full[wr_sel]; it SHALL be combinational from registered state only, never from in_valid.
REQ-007 On an input transfer:
  - lanes 0..7 SHALL be written to bank[wr_sel]
  - full[wr_sel] SHALL be set
  - wr_sel SHALL toggle.
REQ-008 out_valid SHALL equal full[rd_sel].
REQ-009 out_data SHALL equal bank[rd_sel][lane_cnt], where lane_cnt is 3 bits.
REQ-010 An output transfer SHALL occur only when out_valid=1 and out_ready=1.
REQ-011 On an output transfer, lane_cnt SHALL increment.
REQ-012 On an output transfer with lane_cnt=7:
  - lane_cnt SHALL wrap to 0
  - full[rd_sel] SHALL clear
  - rd_sel SHALL toggle.
REQ-013 Latency: a beat accepted at edge N SHALL present lane 0 with out_valid=1 in the cycle after edge N, when the read bank was empty.
REQ-014 With out_ready held at 1, the block SHALL sustain one pixel per cycle. A new beat SHALL be accepted while the other bank drains, giving gap-free output across beats.
REQ-015 A same-cycle input transfer and final-lane output transfer SHALL both take effect. They always target different banks. No pixel SHALL be lost or duplicated.
REQ-016 When both banks are full, in_ready SHALL be 0 and in_data SHALL be ignored.
REQ-017 With out_ready=0, out_data, out_eol and out_eof SHALL hold stable while out_valid=1.
REQ-018 The column counter col (0..WIDTH-1) SHALL advance on every output transfer and wrap at WIDTH-1. The row counter row (0..HEIGHT-1) SHALL advance when col wraps.
REQ-019 out_eol SHALL be 1 when out_valid=1 and col=WIDTH-1.
REQ-020 out_eof SHALL be 1 when out_eol=1 and row=HEIGHT-1.
REQ-021 After an output transfer with out_eof=1:
  - frame_done SHALL be 1 for exactly the next cycle
  - row and col SHALL be 0
  - the next frame SHALL proceed without any idle requirement.
REQ-022 out_valid=0 SHALL never advance any counter, regardless of out_ready.

Reset
REQ-023 When rst=0, the block SHALL immediately, without waiting for clk, force:
  - both full flags, wr_sel, rd_sel, lane_cnt, col and row to 0
  - out_valid, out_eol, out_eof and frame_done to 0
  - in_ready to 1.
REQ-024 out_data SHALL be 0 during reset; bank contents need not clear.
REQ-025 Reset asserted mid-frame SHALL discard all buffered pixels. After release, the first accepted beat SHALL start at row 0, col 0.

Verification
REQ-026 Single beat, in_data_k=k+1, out_ready=1: out_data sequence 1..8 on consecutive cycles; out_eol=1 on the 8th pixel; out_valid=0 afterwards.
REQ-027 Back-to-back, with in_valid and out_ready held at 1 for 8 beats (one 8x8 frame):
  - 64 contiguous pixels with no out_valid gaps after the first
  - out_eol every 8th pixel
  - out_eof only on pixel 64
  - frame_done pulses once, one cycle later.
REQ-028 Backpressure, out_ready=0 and three beats offered:
  - the first two beats are accepted
  - in_ready=0 for the third, which is held until out_ready=1 and the first bank drains, then accepted
  - out_data stays frozen at lane 0 of beat 1 throughout the stall.
REQ-029 Random out_ready (50%) and random in_valid over 3 frames: the scoreboard matches every pixel in order; eol/eof positions are correct; frame_done count is 3.
REQ-030 Assert rst=0 asynchronously after 3 beats of a frame, between clock edges:
  - outputs clear within the same cycle
  - in_ready=1
  - the next frame's first pixel carries col=0 and row=0 (out_eol first seen on its 8th pixel).
REQ-031 Simultaneity: an input transfer on the same edge as the final-lane output transfer gives no gap and no duplicate; check the pixel index continuity.
